// File: rtl/temp_disp_ctrl_if.sv
// Read-engine handshake between temp_disp_ctrl (master) and the LM75A I2C read engine (slave).
interface temp_disp_ctrl_if;
    logic        rd_req;
    logic        rd_ack;
    logic        rd_done;
    logic        rd_err;
    logic [15:0] rd_data;

    modport master (
        output rd_req,
        input  rd_ack,
        input  rd_done,
        input  rd_err,
        input  rd_data
    );

    modport slave (
        input  rd_req,
        output rd_ack,
        output rd_done,
        output rd_err,
        output rd_data
    );
endinterface

// File: rtl/temp_disp_ctrl.sv
// Temperature sampling scheduler and BCD display formatter sitting between the
// LM75A read engine and the 7-segment scan driver.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for a pending sample request
// REQ    | rd_req high, waiting for rd_ack (timeout armed)
// WAIT   | request accepted, waiting for registered rd_done / rd_err
// CONV   | 8 double-dabble iterations on the integer part
// UPDATE | publish result, pulse upd, clear err, set disp_valid
module temp_disp_ctrl #(
    parameter int SAMPLE_CYC  = 25_000_000,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     trig_i,
    temp_disp_ctrl_if.master         bus,
    output logic [15:0]              disp_data_o,
    output logic                     disp_neg_o,
    output logic                     disp_valid_o,
    output logic                     upd_o,
    output logic                     err_o
);

    localparam int PW = (SAMPLE_CYC  > 1) ? $clog2(SAMPLE_CYC)  : 1;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        WAIT   = 3'd2,
        CONV   = 3'd3,
        UPDATE = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] per_q, per_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          pend_q, pend_d;
    logic          done_s_q, err_s_q;
    logic [10:0]   data_s_q;
    logic [10:0]   raw_q, raw_d;
    logic [2:0]    cv_cnt_q, cv_cnt_d;
    logic [19:0]   sh_q, sh_d;
    logic [15:0]   disp_data_q, disp_data_d;
    logic          disp_neg_q, disp_neg_d;
    logic          valid_q, valid_d;
    logic          upd_q, upd_d;
    logic          err_q, err_d;

    logic          tick;
    logic          tmo_exp;
    logic [10:0]   mag;
    logic [5:0]    fr_x5;
    logic [3:0]    tenths;
    logic [19:0]   sh_src;
    logic          unused_rd_lsb;

    assign unused_rd_lsb = ^bus.rd_data[4:0];

    // One double-dabble step: add 3 to any BCD digit >= 5, then shift left.
    function automatic logic [19:0] dd_step(input logic [19:0] s);
        logic [19:0] t;
        t = s;
        if (t[11:8]  >= 4'd5) t[11:8]  = t[11:8]  + 4'd3;
        if (t[15:12] >= 4'd5) t[15:12] = t[15:12] + 4'd3;
        if (t[19:16] >= 4'd5) t[19:16] = t[19:16] + 4'd3;
        return {t[18:0], 1'b0};
    endfunction

    assign tick    = (per_q == PW'(SAMPLE_CYC - 1));
    assign per_d   = tick ? '0 : per_q + PW'(1);
    assign tmo_exp = (tmo_q == TW'(TIMEOUT_CYC - 1));

    assign mag     = raw_q[10] ? (~raw_q + 11'd1) : raw_q;
    assign fr_x5   = {1'b0, mag[2:0], 2'b00} + {3'b000, mag[2:0]};
    assign tenths  = fr_x5[5:2];
    assign sh_src  = (cv_cnt_q == 3'd0) ? {12'd0, mag[10:3]} : sh_q;

    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        tmo_d       = '0;
        raw_d       = raw_q;
        cv_cnt_d    = cv_cnt_q;
        sh_d        = sh_q;
        disp_data_d = disp_data_q;
        disp_neg_d  = disp_neg_q;
        valid_d     = valid_q;
        upd_d       = 1'b0;
        err_d       = err_q;

        if (tick || trig_i) pend_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    state_d = REQ;
                    pend_d  = 1'b0;
                end
            end
            REQ: begin
                tmo_d = tmo_q + TW'(1);
                if (bus.rd_ack) begin
                    state_d = WAIT;
                end else if (tmo_exp) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            WAIT: begin
                tmo_d = tmo_q + TW'(1);
                if (done_s_q) begin
                    raw_d    = data_s_q;
                    cv_cnt_d = 3'd0;
                    state_d  = CONV;
                end else if (err_s_q || tmo_exp) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            CONV: begin
                sh_d     = dd_step(sh_src);
                cv_cnt_d = cv_cnt_q + 3'd1;
                if (cv_cnt_q == 3'd7) state_d = UPDATE;
            end
            UPDATE: begin
                disp_data_d = {sh_q[19:8], tenths};
                disp_neg_d  = raw_q[10];
                valid_d     = 1'b1;
                upd_d       = 1'b1;
                err_d       = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Engine responses are registered, and only accepted while waiting for them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_s_q <= 1'b0;
            err_s_q  <= 1'b0;
            data_s_q <= '0;
        end else begin
            done_s_q <= bus.rd_done && (state_q == WAIT);
            err_s_q  <= bus.rd_err  && (state_q == WAIT);
            if (bus.rd_done && (state_q == WAIT)) data_s_q <= bus.rd_data[15:5];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            per_q       <= '0;
            tmo_q       <= '0;
            pend_q      <= 1'b0;
            raw_q       <= '0;
            cv_cnt_q    <= '0;
            sh_q        <= '0;
            disp_data_q <= '0;
            disp_neg_q  <= 1'b0;
            valid_q     <= 1'b0;
            upd_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            per_q       <= per_d;
            tmo_q       <= tmo_d;
            pend_q      <= pend_d;
            raw_q       <= raw_d;
            cv_cnt_q    <= cv_cnt_d;
            sh_q        <= sh_d;
            disp_data_q <= disp_data_d;
            disp_neg_q  <= disp_neg_d;
            valid_q     <= valid_d;
            upd_q       <= upd_d;
            err_q       <= err_d;
        end
    end

    assign bus.rd_req   = (state_q == REQ);
    assign disp_data_o  = disp_data_q;
    assign disp_neg_o   = disp_neg_q;
    assign disp_valid_o = valid_q;
    assign upd_o        = upd_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_temp_disp_ctrl.sv
// Scoreboard bench for temp_disp_ctrl: engine model driven from one thread,
// expected display words queued on rd_done and checked when upd pulses.
module tb_temp_disp_ctrl;
    localparam int SAMPLE_CYC  = 100;
    localparam int TIMEOUT_CYC = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        trig = 1'b0;
    logic [15:0] disp_data;
    logic        disp_neg, disp_valid, upd, err;

    temp_disp_ctrl_if bus();

    temp_disp_ctrl #(.SAMPLE_CYC(SAMPLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .trig_i       (trig),
        .bus          (bus),
        .disp_data_o  (disp_data),
        .disp_neg_o   (disp_neg),
        .disp_valid_o (disp_valid),
        .upd_o        (upd),
        .err_o        (err)
    );

    typedef struct {
        logic [15:0] d;
        logic        n;
        int          c;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   upd_n = 0;
    bit   upd_prev = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            upd_prev = 1'b0;
        end else begin
            if (upd_prev) chk("upd_1cyc", upd, 1'b0);
            upd_prev = upd;
            if (upd) begin
                upd_n++;
                if (sb_q.size() == 0) begin
                    chk("upd_spurious", 1, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("disp_data", disp_data, mon_e.d);
                    chk("disp_neg", disp_neg, mon_e.n);
                    chk("upd_lat", cyc, mon_e.c);
                    chk("disp_valid", disp_valid, 1'b1);
                    chk("err_clr", err, 1'b0);
                end
            end
        end
    end

    task automatic wait_req(input string tag, input int bound, output int r);
        r = -1;
        for (int i = 0; i < bound; i++) begin
            if (r < 0) begin
                @(negedge clk);
                if (bus.rd_req) r = cyc;
            end
        end
        if (r < 0) chk(tag, 0, 1);
    endtask

    // Called at the negedge where rd_req was first seen: ack at +2, done/err at +3.
    task automatic serve(input logic [15:0] d, input logic [15:0] exp_d, input logic exp_n,
                         input bit use_err, output int dc);
        exp_t e;
        @(negedge clk);
        chk("req_hold", bus.rd_req, 1'b1);
        bus.rd_ack = 1'b1;
        @(negedge clk);
        bus.rd_ack = 1'b0;
        chk("req_drop", bus.rd_req, 1'b0);
        dc = cyc;
        if (use_err) begin
            bus.rd_err = 1'b1;
        end else begin
            bus.rd_data = d;
            bus.rd_done = 1'b1;
            e.d = exp_d;
            e.n = exp_n;
            e.c = cyc + 11;
            sb_q.push_back(e);
        end
        @(negedge clk);
        bus.rd_done = 1'b0;
        bus.rd_err  = 1'b0;
        bus.rd_data = 16'h0000;
    endtask

    task automatic drain(input int bound);
        for (int i = 0; i < bound; i++)
            if (sb_q.size() != 0) @(negedge clk);
        chk("sb_drain", sb_q.size(), 0);
    endtask

    logic [15:0] sw_in [5] = '{16'hE700, 16'h7D00, 16'h0020, 16'hFFE0, 16'h1880};
    logic [15:0] sw_d  [5] = '{16'h0250, 16'h1250, 16'h0001, 16'h0001, 16'h0245};
    logic        sw_n  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        int r, prev, c0, dc, n0;
        bus.rd_ack  = 1'b0;
        bus.rd_done = 1'b0;
        bus.rd_err  = 1'b0;
        bus.rd_data = 16'h0000;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req", bus.rd_req, 1'b0);
        chk("rst_data", disp_data, 16'h0000);
        chk("rst_neg", disp_neg, 1'b0);
        chk("rst_valid", disp_valid, 1'b0);
        chk("rst_upd", upd, 1'b0);
        chk("rst_err", err, 1'b0);
        rst_n = 1'b1;
        c0 = cyc;

        wait_req("req_first", 150, r);
        chk("req_first_cyc", r, c0 + 101);
        serve(16'h1900, 16'h0250, 1'b0, 1'b0, dc);
        drain(20);
        chk("valid_set", disp_valid, 1'b1);
        prev = r;

        for (int i = 0; i < 5; i++) begin
            wait_req("req_sweep", 150, r);
            chk("req_period", r - prev, 100);
            prev = r;
            serve(sw_in[i], sw_d[i], sw_n[i], 1'b0, dc);
            drain(20);
        end

        // engine never acks
        wait_req("req_noack", 150, r);
        chk("req_period_na", r - prev, 100);
        prev = r;
        for (int i = 0; i < 40; i++)
            if (bus.rd_req) @(negedge clk);
        chk("tmo_len", cyc - r, TIMEOUT_CYC);
        chk("err_tmo", err, 1'b1);
        chk("disp_hold_tmo", disp_data, 16'h0245);
        chk("valid_hold_tmo", disp_valid, 1'b1);

        wait_req("req_recover", 150, r);
        chk("req_period_rc", r - prev, 100);
        prev = r;
        serve(16'h0020, 16'h0001, 1'b0, 1'b0, dc);
        drain(20);
        chk("err_cleared", err, 1'b0);

        // three trigs during CONV collapse into one extra read
        wait_req("req_trig", 150, r);
        prev = r;
        serve(16'h1880, 16'h0245, 1'b0, 1'b0, dc);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            trig = 1'b1;
            @(negedge clk);
            trig = 1'b0;
        end
        wait_req("req_extra", 30, r);
        chk("req_extra_cyc", r, dc + 12);
        serve(16'h7D00, 16'h1250, 1'b0, 1'b0, dc);
        drain(20);
        wait_req("req_after_extra", 150, r);
        chk("req_no_dup", r, prev + 100);
        prev = r;
        serve(16'hE700, 16'h0250, 1'b1, 1'b0, dc);
        drain(20);

        // trig lands in the same cycle as tick
        while (cyc < prev + 98) @(negedge clk);
        trig = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        wait_req("req_ticktrig", 150, r);
        chk("req_ticktrig_cyc", r, prev + 100);
        prev = r;
        serve(16'hFFE0, 16'h0001, 1'b1, 1'b0, dc);
        drain(20);
        wait_req("req_one_read", 150, r);
        chk("req_one_read_cyc", r, prev + 100);
        prev = r;

        // rd_err in WAIT, then a stray rd_done in IDLE
        n0 = upd_n;
        serve(16'h0000, 16'h0000, 1'b0, 1'b1, dc);
        repeat (3) @(negedge clk);
        chk("err_rderr", err, 1'b1);
        chk("req_idle_rderr", bus.rd_req, 1'b0);
        bus.rd_data = 16'h1900;
        bus.rd_done = 1'b1;
        @(negedge clk);
        bus.rd_done = 1'b0;
        repeat (15) @(negedge clk);
        chk("no_upd_rderr", upd_n, n0);
        chk("disp_hold_rderr", disp_data, 16'h0001);
        chk("neg_hold_rderr", disp_neg, 1'b1);

        // asynchronous reset while in WAIT
        wait_req("req_rst", 150, r);
        @(negedge clk);
        bus.rd_ack = 1'b1;
        @(negedge clk);
        bus.rd_ack = 1'b0;
        chk("err_pre_rst", err, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req", bus.rd_req, 1'b0);
        chk("arst_upd", upd, 1'b0);
        chk("arst_err", err, 1'b0);
        chk("arst_data", disp_data, 16'h0000);
        chk("arst_valid", disp_valid, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        c0 = cyc;
        bus.rd_data = 16'h1900;
        bus.rd_done = 1'b1;
        @(negedge clk);
        bus.rd_done = 1'b0;
        wait_req("req_resume", 150, r);
        chk("req_resume_cyc", r, c0 + 101);
        chk("valid_after_rst", disp_valid, 1'b0);
        serve(16'h1900, 16'h0250, 1'b0, 1'b0, dc);
        drain(20);
        chk("valid_resume", disp_valid, 1'b1);

        repeat (5) @(negedge clk);
        chk("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired cyc=%0d", cyc);
        $fatal(1);
    end

endmodule

// File: doc/temp_disp_ctrl.md
# temp_disp_ctrl

Sampling scheduler and display formatter between the LM75A I2C read engine and the 4-digit 7-segment scan driver. It triggers a temperature read every SAMPLE_CYC clocks, or on demand, and handles the request/acknowledge/done handshake with timeout. It converts the raw 11-bit two's-complement reading to packed BCD (hundreds, tens, ones, tenths) plus a sign flag. The result is held on `disp_data` for the scan driver until the next successful sample.

## Interface
- SAMPLE_CYC, 25_000_000: sample period in clocks (500 ms at 50 MHz); ≥ 32.
- TIMEOUT_CYC, 1_000_000: max clocks from entering REQ to `rd_done`; ≥ 2.
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- trig  in  1  one-cycle on-demand sample request.
- rd_req  out  1  read request to I2C engine; level, held until `rd_ack`.
- rd_ack  in  1  engine accepted request (one-cycle pulse).
- rd_done  in  1  read complete, `rd_data` valid this cycle (pulse).
- rd_err  in  1  read failed (NACK), pulse in place of `rd_done`.
- rd_data  in  16  LM75A temperature register; bits [15:5] = temp ×8, two's complement.
- disp_data  out  16  {hundreds, tens, ones, tenths} BCD nibbles.
- disp_neg  out  1  displayed value is negative.
- disp_valid  out  1  at least one successful sample since reset.
- upd  out  1  one-cycle pulse when `disp_data` changes.
- err  out  1  sticky: last attempt timed out or returned `rd_err`.

## Operation
- Period counter: free-running 0..SAMPLE_CYC-1. `tick` fires when the count equals SAMPLE_CYC-1. The counter is never reset by the FSM.
- `pend` flag: set by `tick` or `trig`, cleared on entry to REQ.
  - One-deep: extra ticks or trigs while `pend` is already set are dropped.
  - A tick or trig arriving in any non-IDLE state sets `pend`; one more read follows.
- FSM states: IDLE, REQ, WAIT, CONV, UPDATE.
  - IDLE: if `pend`, go to REQ.
  - REQ: `rd_req`=1. On `rd_ack`, go to WAIT.
  - WAIT: `rd_req`=0. On `rd_done`, latch `rd_data[15:5]` into `raw` and go to CONV. On `rd_err`, go to IDLE and set `err`.
  - CONV: exactly 8 cycles, then go to UPDATE.
  - UPDATE: write outputs, pulse `upd`, clear `err`, set `disp_valid`, go to IDLE.
- Timeout counter: cleared on entry to REQ, counts in REQ and WAIT.
  - At TIMEOUT_CYC, go to IDLE, drop `rd_req`, set `err`.
  - `disp_data`, `disp_neg` and `disp_valid` are unchanged on timeout or error.
- `rd_done` or `rd_err` outside WAIT is ignored. The engine guarantees `rd_done` is at least 1 cycle after `rd_ack`.
- Conversion, 11-bit signed `raw`:
  - `neg` = raw[10]; `mag` = neg ? −raw : raw, 11 bits unsigned.
  - Integer part `int` = mag[10:3] (≤125). Fraction `fr` = mag[2:0].
  - tenths = (fr×5)>>2, i.e. 0,1,2,3,5,6,7,8 for fr = 0..7 (truncating).
  - `int` goes through 8-cycle shift-add-3 (double-dabble) in CONV to give hundreds, tens, ones.
  - −0.0 cannot occur. The raw value −1024 (mag 1024) is out of sensor range; the result is undefined but must not hang the FSM.

## Timing
- Reset values: `rd_req`=0, `disp_data`=16'h0000, `disp_neg`=0, `disp_valid`=0, `upd`=0, `err`=0. FSM=IDLE, period counter=0, `pend`=0.
- Reset mid-transaction forces IDLE immediately and drops `rd_req`. A late `rd_done` after reset is ignored.
- Edge E samples `rd_done`=1:
  - `disp_data`, `disp_neg` and `upd`=1 appear after edge E+10, i.e. 1 WAIT exit + 8 CONV + 1 UPDATE.
  - `upd` is high for exactly one cycle.
- `rd_req` rises on the edge entering REQ. It falls on the edge after `rd_ack` is sampled.
- Tick and trig in the same cycle set `pend` once, giving one read.
- With `pend` set in IDLE, the next edge enters REQ; `rd_req` is visible 1 cycle after `pend`.

## Test plan
- SAMPLE_CYC=100, TIMEOUT_CYC=20 for all scenarios.
- Reset release, model responds with ack at +2 and done at +3: `rd_data`=16'h1900 → `disp_data`=16'h0250, `disp_neg`=0, `upd` pulse exactly 10 edges after done, `disp_valid`=1. Next `rd_req` follows at the following tick, 100-cycle spacing.
- Value sweep: 16'hE700 → 0250/neg 1; 16'h7D00 → 1250/neg 0; 16'h0020 → 0001/neg 0; 16'hFFE0 → 0001/neg 1; 16'h1880 → 0245/neg 0.
- Model never acks: `rd_req` drops after 20 cycles, `err`=1, `disp_data` keeps its prior value. The next good read clears `err`.
- `rd_err` pulse in WAIT: `err`=1, no `upd`, return to IDLE. `rd_done` pulsed in IDLE has no effect.
- `trig` pulsed 3 times during CONV → exactly one extra read; tick and trig in the same cycle → one read.
- Assert `rst_n`=0 while in WAIT: `rd_req`, `upd` and `err` go to 0 and `disp_data` to 0000 asynchronously. Resume cleanly on the next tick.
